// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for mem_ctrl: FSM state encoding and load/store size codes.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIfRd = 2'd1,
    StLsRd = 2'd2,
    StLsWr = 2'd3
  } state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Byte count for a load/store; the reserved code 2'b11 behaves as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-wide RAM arbiter: serialises instruction fetches and 1/2/4-byte loads/stores
// onto one 8-bit RAM port and returns little-endian words with a one-cycle done pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [1:0]        ls_size,
  input  logic [31:0]       ls_wdata,
  output logic [31:0]       ls_rdata,
  output logic              ls_done,
  input  logic              flush
);

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          n_q, n_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         buf_q, buf_d;
  logic [31:0]         if_data_q, if_data_d;
  logic [31:0]         ls_rdata_q, ls_rdata_d;
  logic                if_done_q, if_done_d;
  logic                ls_done_q, ls_done_d;
  logic [1:0]          byte_idx;

  assign if_done  = if_done_q;
  assign ls_done  = ls_done_q;
  assign if_data  = if_data_q;
  assign ls_rdata = ls_rdata_q;

  // RAM port is decoded from the current state; reads stop issuing once k reaches n.
  always_comb begin
    mem_a    = '0;
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
    unique case (state_q)
      StIfRd, StLsRd: begin
        if (cnt_q != n_q) mem_a = base_q + ADDR_W'(cnt_q);
      end
      StLsWr: begin
        mem_a  = base_q + ADDR_W'(cnt_q);
        mem_wr = rdy_in;
        unique case (cnt_q[1:0])
          2'd0: mem_dout = wdata_q[7:0];
          2'd1: mem_dout = wdata_q[15:8];
          2'd2: mem_dout = wdata_q[23:16];
          2'd3: mem_dout = wdata_q[31:24];
          default: mem_dout = 8'h00;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    byte_idx   = cnt_q[1:0] - 2'd1;

    if (!rdy_in) begin
      if_done_d = if_done_q;
      ls_done_d = ls_done_q;
      // The RAM read pipeline keeps running during a stall, so reads start over.
      if (state_q == StIfRd || state_q == StLsRd) cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!if_done_q && !ls_done_q) begin
            if (ls_req) begin
              state_d = ls_we ? StLsWr : StLsRd;
              base_d  = ls_addr;
              n_d     = size_bytes(ls_size);
              wdata_d = ls_wdata;
              buf_d   = '0;
              cnt_d   = '0;
            end else if (if_req && !flush) begin
              state_d = StIfRd;
              base_d  = if_addr;
              n_d     = 3'd4;
              buf_d   = '0;
              cnt_d   = '0;
            end
          end
        end
        StIfRd, StLsRd: begin
          if (state_q == StIfRd && flush) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            if (cnt_q != 3'd0) buf_d[8*byte_idx +: 8] = mem_din;
            if (cnt_q == n_q) begin
              state_d = StIdle;
              cnt_d   = '0;
              if (state_q == StIfRd) begin
                if_done_d = 1'b1;
                if_data_d = buf_d;
              end else begin
                ls_done_d  = 1'b1;
                ls_rdata_d = buf_d;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        StLsWr: begin
          if (cnt_q == n_q - 3'd1) begin
            state_d   = StIdle;
            cnt_d     = '0;
            ls_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      n_q        <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: table of directed transactions plus hand-written
// sequences for contention, flush, stall and mid-transaction reset.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [1:0]  ls_size;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_done;
  logic        flush;

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .mem_a    (mem_a),
    .mem_wr   (mem_wr),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_done  (if_done),
    .if_data  (if_data),
    .ls_req   (ls_req),
    .ls_we    (ls_we),
    .ls_addr  (ls_addr),
    .ls_size  (ls_size),
    .ls_wdata (ls_wdata),
    .ls_rdata (ls_rdata),
    .ls_done  (ls_done),
    .flush    (flush)
  );

  // Synchronous byte RAM: read data appears one cycle after the address.
  logic [7:0]  ram [0:4095];
  logic        ld_en;
  logic [11:0] ld_a;
  logic [7:0]  ld_d;

  always @(posedge clk_in) begin
    if (ld_en) ram[ld_a] <= ld_d;
    else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    mem_din <= ram[mem_a[11:0]];
  end

  typedef struct {
    logic        is_ls;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_wr;
  } txn_t;

  txn_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_in);
    #1;
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk_in);
    ld_a  = a;
    ld_d  = d;
    ld_en = 1'b1;
    @(negedge clk_in);
    ld_en = 1'b0;
  endtask

  task automatic poke_word(input logic [11:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [11:0] ai;
      ai = a + 12'(i);
      poke(ai, w[8*i +: 8]);
    end
  endtask

  task automatic run_txn(input int id, input txn_t t);
    int          lat;
    int          wrs;
    int          stray;
    bit          seen;
    logic [31:0] got;
    step();
    check($sformatf("txn%0d_idle_done", id), {30'd0, if_done, ls_done}, 32'd0);
    if (t.is_ls) begin
      ls_req   = 1'b1;
      ls_we    = t.we;
      ls_addr  = t.addr;
      ls_size  = t.size;
      ls_wdata = t.wdata;
    end else begin
      if_req  = 1'b1;
      if_addr = t.addr;
    end
    lat = 0; wrs = 0; stray = 0; seen = 1'b0; got = '0;
    for (int c = 1; c <= 16 && !seen; c++) begin
      step();
      if (mem_wr) wrs++;
      if (t.is_ls ? if_done : ls_done) stray++;
      if (t.is_ls ? ls_done : if_done) begin
        seen   = 1'b1;
        lat    = c;
        got    = t.is_ls ? ls_rdata : if_data;
        ls_req = 1'b0;
        if_req = 1'b0;
      end
    end
    if (!seen) begin
      ls_req = 1'b0;
      if_req = 1'b0;
    end
    check($sformatf("txn%0d_latency", id), 32'(lat), 32'(t.exp_lat));
    check($sformatf("txn%0d_write_cycles", id), 32'(wrs), 32'(t.exp_wr));
    check($sformatf("txn%0d_other_done", id), 32'(stray), 32'd0);
    if (!(t.is_ls && t.we)) check($sformatf("txn%0d_data", id), got, t.exp_data);
  endtask

  initial begin
    int ls_at;
    int if_at;
    int both;
    int cnt;
    int wrs;
    int lat;

    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_size = 2'b00; ls_wdata = '0;
    ld_en = 1'b0; ld_a = '0; ld_d = '0;

    //             is_ls we    size   addr          wdata         exp_data      lat wr
    tbl[0]  = '{1'b1, 1'b1, 2'b01, 32'h0000_0020, 32'h0000_BEEF, 32'h0,        3, 2};
    tbl[1]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0021, 32'h0,         32'h0000_00BE, 3, 0};
    tbl[2]  = '{1'b1, 1'b0, 2'b01, 32'h0000_0020, 32'h0,         32'h0000_BEEF, 4, 0};
    tbl[3]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0,         32'h00A0_0513, 6, 0};
    tbl[4]  = '{1'b1, 1'b1, 2'b10, 32'h0000_0030, 32'h89AB_CDEF, 32'h0,        5, 4};
    tbl[5]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0030, 32'h0,         32'h89AB_CDEF, 6, 0};
    tbl[6]  = '{1'b1, 1'b1, 2'b00, 32'h0000_0031, 32'hFFFF_FF5A, 32'h0,        2, 1};
    tbl[7]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0030, 32'h0,         32'h89AB_5AEF, 6, 0};
    tbl[8]  = '{1'b1, 1'b0, 2'b11, 32'h0000_0030, 32'h0,         32'h89AB_5AEF, 6, 0};
    tbl[9]  = '{1'b1, 1'b1, 2'b10, 32'hFFFF_FFFF, 32'h0102_0304, 32'h0,        5, 4};
    tbl[10] = '{1'b1, 1'b0, 2'b10, 32'hFFFF_FFFF, 32'h0,         32'h0102_0304, 6, 0};
    tbl[11] = '{1'b0, 1'b0, 2'b10, 32'h0000_0200, 32'h0,         32'h1234_5678, 6, 0};

    poke_word(12'h100, 32'h00A0_0513);
    poke_word(12'h200, 32'h1234_5678);
    poke_word(12'h040, 32'h1122_3344);
    poke_word(12'h010, 32'hDEAD_BEEF);
    poke(12'h342, 8'h55);
    poke(12'h343, 8'h55);

    step();
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'h0);
    check("rst_if_done", {31'd0, if_done}, 32'h0);
    check("rst_ls_done", {31'd0, ls_done}, 32'h0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_ls_rdata", ls_rdata, 32'h0);
    rst_in = 1'b0;

    for (int i = 0; i < 12; i++) run_txn(i, tbl[i]);

    // Simultaneous requests: load wins, one bubble, then the fetch.
    step();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40; ls_size = 2'b10;
    if_req = 1'b1; if_addr = 32'h10;
    ls_at = 0; if_at = 0; both = 0;
    for (int c = 1; c <= 24; c++) begin
      step();
      if (ls_done && if_done) both++;
      if (ls_done && ls_at == 0) begin ls_at = c; ls_req = 1'b0; end
      if (if_done && if_at == 0) begin if_at = c; if_req = 1'b0; end
    end
    ls_req = 1'b0; if_req = 1'b0;
    check("contend_ls_cycle", 32'(ls_at), 32'd6);
    check("contend_if_cycle", 32'(if_at), 32'd13);
    check("contend_overlap", 32'(both), 32'd0);
    check("contend_ls_data", ls_rdata, 32'h1122_3344);
    check("contend_if_data", if_data, 32'hDEAD_BEEF);

    // Flush two cycles into a fetch.
    step(); if_req = 1'b1; if_addr = 32'h100;
    step();
    step(); flush = 1'b1;
    check("flush_running_addr", mem_a, 32'h101);
    step(); flush = 1'b0; if_req = 1'b0;
    check("flush_idle_addr", mem_a, 32'h0);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (if_done) cnt++;
    end
    check("flush_no_done", 32'(cnt), 32'd0);

    // Flush while a fetch request is seen in IDLE.
    step(); if_req = 1'b1; if_addr = 32'h100; flush = 1'b1;
    step();
    check("flush_idle_req_addr", mem_a, 32'h0);
    if_req = 1'b0; flush = 1'b0;
    run_txn(20, tbl[11]);

    // Flush must not disturb a load.
    flush = 1'b1;
    run_txn(21, '{1'b1, 1'b0, 2'b10, 32'h40, 32'h0, 32'h1122_3344, 6, 0});
    flush = 1'b0;

    // Stall mid word read: restarts from byte 0.
    step(); if_req = 1'b1; if_addr = 32'h200;
    wrs = 0; lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      step();
      if (c == 3) rdy_in = 1'b0;
      if (c == 6) rdy_in = 1'b1;
      if (mem_wr) wrs++;
      if (if_done) begin lat = c; if_req = 1'b0; end
    end
    if_req = 1'b0; rdy_in = 1'b1;
    check("stall_rd_latency", 32'(lat), 32'd11);
    check("stall_rd_data", if_data, 32'h1234_5678);
    check("stall_rd_no_write", 32'(wrs), 32'd0);

    // Stall mid word store: resumes at the current byte with mem_wr forced low.
    step(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h300; ls_size = 2'b10;
    ls_wdata = 32'hA1B2_C3D4;
    wrs = 0; lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      step();
      if (c == 2) begin
        rdy_in = 1'b0;
        #1;
        check("stall_wr_forced_low", {31'd0, mem_wr}, 32'h0);
      end
      if (c == 4) begin rdy_in = 1'b1; #1; end
      if (mem_wr) wrs++;
      if (ls_done) begin lat = c; ls_req = 1'b0; end
    end
    ls_req = 1'b0; rdy_in = 1'b1;
    check("stall_wr_latency", 32'(lat), 32'd7);
    check("stall_wr_cycles", 32'(wrs), 32'd4);
    check("stall_wr_ram", {ram[12'h303], ram[12'h302], ram[12'h301], ram[12'h300]},
          32'hA1B2_C3D4);

    // Reset after two bytes of a word store.
    step(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h340; ls_size = 2'b10;
    ls_wdata = 32'hCAFE_F00D;
    step();
    step(); rst_in = 1'b1;
    step();
    check("rstmid_mem_wr", {31'd0, mem_wr}, 32'h0);
    check("rstmid_mem_a", mem_a, 32'h0);
    check("rstmid_mem_dout", {24'd0, mem_dout}, 32'h0);
    check("rstmid_ls_rdata", ls_rdata, 32'h0);
    check("rstmid_if_data", if_data, 32'h0);
    rst_in = 1'b0; ls_req = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (ls_done || if_done) cnt++;
    end
    check("rstmid_no_done", 32'(cnt), 32'd0);
    check("rstmid_ram", {ram[12'h343], ram[12'h342], ram[12'h341], ram[12'h340]},
          32'h5555_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
